// File: rtl/sdr_req_arbiter_if.sv
// -----------------------------------------------------------------------------
// sdr_req_arbiter_if
// Bundles the signals of the SDRAM front-end scheduler: the two requester
// ports (m0/m1), the controller system bus and the refresh handshake.
//
// Modports:
//   master : arbiter view. It receives requests and controller status and
//            drives grants, completions, read data and the controller bus.
//   slave  : environment view (requesters plus controller), the mirror image.
//
// Handshake rules:
//   Requester : m_req[i] is a level. m_wr/addr/wdata are held stable until
//               m_gnt[i] pulses. m_req[i] is dropped the cycle after m_gnt[i]
//               unless another access is wanted. Dropping it before the grant
//               withdraws the request.
//   Access    : sys_ADSn pulses low for one cycle, one cycle after m_gnt.
//               sys_D_VALID captures sys_D_in. sys_CYC_END ends the access,
//               and m_done pulses on the following cycle.
//   Refresh   : sys_REF_REQ stays high until sys_REF_ACK is seen. After the
//               ack the arbiter waits for sys_CYC_END.
// -----------------------------------------------------------------------------
interface sdr_req_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) ();
    logic              sys_INIT_DONE;
    logic [1:0]        m_req;
    logic [1:0]        m_wr;
    logic [ADDR_W-1:0] m0_addr;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic [DATA_W-1:0] m1_wdata;
    logic [1:0]        m_gnt;
    logic [1:0]        m_done;
    logic [1:0]        rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              sys_ADSn;
    logic              sys_R_Wn;
    logic [ADDR_W-1:0] sys_A;
    logic [DATA_W-1:0] sys_D;
    logic [DATA_W-1:0] sys_D_in;
    logic              sys_D_VALID;
    logic              sys_CYC_END;
    logic              sys_REF_REQ;
    logic              sys_REF_ACK;
    logic              ref_ovf;

    modport master (
        input  sys_INIT_DONE, m_req, m_wr, m0_addr, m1_addr, m0_wdata, m1_wdata,
               sys_D_in, sys_D_VALID, sys_CYC_END, sys_REF_ACK,
        output m_gnt, m_done, rd_valid, rd_data, sys_ADSn, sys_R_Wn, sys_A,
               sys_D, sys_REF_REQ, ref_ovf
    );

    modport slave (
        output sys_INIT_DONE, m_req, m_wr, m0_addr, m1_addr, m0_wdata, m1_wdata,
               sys_D_in, sys_D_VALID, sys_CYC_END, sys_REF_ACK,
        input  m_gnt, m_done, rd_valid, rd_data, sys_ADSn, sys_R_Wn, sys_A,
               sys_D, sys_REF_REQ, ref_ovf
    );
endinterface

// File: rtl/sdr_req_arbiter.sv
// -----------------------------------------------------------------------------
// sdr_req_arbiter
// Front-end scheduler for the SDRAM controller. It shares the single
// controller port between two requesters using round-robin arbitration. It
// also generates periodic auto-refresh credits and keeps a pending-refresh
// backlog. Refresh waits while traffic is present and is forced once the
// backlog reaches REF_URGENT.
//
// Ports:
//   sys_CLK     : clock
//   sys_RESET   : synchronous, active-low reset
//   bus         : sdr_req_arbiter_if.master (requesters + controller bus)
//   dbg_state_o : current FSM state
//   dbg_pend_o  : pending-refresh backlog
//   dbg_timer_o : refresh interval timer (zero-extended)
// -----------------------------------------------------------------------------
module sdr_req_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 16,
    parameter int REF_INTERVAL = 390,
    parameter int REF_URGENT   = 4
) (
    input  logic               sys_CLK,
    input  logic               sys_RESET,
    sdr_req_arbiter_if.master  bus,
    output logic [2:0]         dbg_state_o,
    output logic [2:0]         dbg_pend_o,
    output logic [15:0]        dbg_timer_o
);
    localparam int TW = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;
    localparam logic [TW-1:0] TMAX = TW'(REF_INTERVAL - 1);
    localparam logic [2:0]    URG  = 3'(REF_URGENT);

    typedef enum logic [2:0] {
        A_WAIT_INIT = 3'd0,
        A_IDLE      = 3'd1,
        A_ISSUE     = 3'd2,
        A_BUSY      = 3'd3,
        A_REF       = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [2:0]        pend_q, pend_d;
    logic              ovf_q, ovf_d;
    logic              last_q, last_d;      // index of the master granted last
    logic              gidx_q, gidx_d;      // master owning the current access
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              rwn_q, rwn_d;
    logic              adsn_q, adsn_d;
    logic              refreq_q, refreq_d;
    logic [1:0]        gnt_q, gnt_d;
    logic [1:0]        done_q, done_d;
    logic [1:0]        rdv_q, rdv_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic credit;
    logic ref_ack;
    logic win;

    // A tie goes to the master that was not granted last. Otherwise the
    // master that is requesting wins.
    assign win     = (bus.m_req == 2'b11) ? ~last_q : bus.m_req[1];
    assign credit  = (state_q != A_WAIT_INIT) && (timer_q == TMAX);
    assign ref_ack = (state_q == A_REF) && refreq_q && bus.sys_REF_ACK;

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        pend_d   = pend_q;
        ovf_d    = ovf_q;
        last_d   = last_q;
        gidx_d   = gidx_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rwn_d    = rwn_q;
        adsn_d   = 1'b1;
        refreq_d = refreq_q;
        gnt_d    = 2'b00;
        done_d   = 2'b00;
        rdv_d    = 2'b00;
        rdata_d  = rdata_q;

        case (state_q)
            A_WAIT_INIT: begin
                if (bus.sys_INIT_DONE) state_d = A_IDLE;
            end
            A_IDLE: begin
                if (pend_q >= URG) begin
                    state_d  = A_REF;
                    refreq_d = 1'b1;
                end else if (|bus.m_req) begin
                    gidx_d  = win;
                    last_d  = win;
                    addr_d  = win ? bus.m1_addr  : bus.m0_addr;
                    wdata_d = win ? bus.m1_wdata : bus.m0_wdata;
                    rwn_d   = ~bus.m_wr[win];
                    gnt_d   = win ? 2'b10 : 2'b01;
                    state_d = A_ISSUE;
                end else if (pend_q != 3'd0) begin
                    state_d  = A_REF;
                    refreq_d = 1'b1;
                end
            end
            A_ISSUE: begin
                adsn_d  = 1'b0;
                state_d = A_BUSY;
            end
            A_BUSY: begin
                if (bus.sys_D_VALID) begin
                    rdata_d = bus.sys_D_in;
                    rdv_d   = gidx_q ? 2'b10 : 2'b01;
                end
                if (bus.sys_CYC_END) begin
                    done_d  = gidx_q ? 2'b10 : 2'b01;
                    state_d = A_IDLE;
                end
            end
            A_REF: begin
                // While refreq_q is high, wait for the ack. After the ack, wait
                // for the controller to finish the refresh cycle.
                if (refreq_q) begin
                    if (bus.sys_REF_ACK) refreq_d = 1'b0;
                end else if (bus.sys_CYC_END) begin
                    state_d = A_IDLE;
                end
            end
            default: state_d = A_WAIT_INIT;
        endcase

        if (state_q != A_WAIT_INIT) begin
            timer_d = credit ? '0 : timer_q + 1'b1;
        end

        // A credit and an ack in the same cycle cancel each other.
        if (credit && !ref_ack) begin
            if (pend_q == 3'd7) ovf_d = 1'b1;
            else                pend_d = pend_q + 3'd1;
        end else if (ref_ack && !credit) begin
            pend_d = pend_q - 3'd1;
        end
    end

    always_ff @(posedge sys_CLK) begin
        if (!sys_RESET) begin
            state_q  <= A_WAIT_INIT;
            timer_q  <= '0;
            pend_q   <= 3'd0;
            ovf_q    <= 1'b0;
            last_q   <= 1'b1;   // marks m1 as granted last, so m0 wins first
            gidx_q   <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rwn_q    <= 1'b1;
            adsn_q   <= 1'b1;
            refreq_q <= 1'b0;
            gnt_q    <= 2'b00;
            done_q   <= 2'b00;
            rdv_q    <= 2'b00;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            pend_q   <= pend_d;
            ovf_q    <= ovf_d;
            last_q   <= last_d;
            gidx_q   <= gidx_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rwn_q    <= rwn_d;
            adsn_q   <= adsn_d;
            refreq_q <= refreq_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            rdv_q    <= rdv_d;
            rdata_q  <= rdata_d;
        end
    end

    assign bus.m_gnt       = gnt_q;
    assign bus.m_done      = done_q;
    assign bus.rd_valid    = rdv_q;
    assign bus.rd_data     = rdata_q;
    assign bus.sys_ADSn    = adsn_q;
    assign bus.sys_R_Wn    = rwn_q;
    assign bus.sys_A       = addr_q;
    assign bus.sys_D       = wdata_q;
    assign bus.sys_REF_REQ = refreq_q;
    assign bus.ref_ovf     = ovf_q;

    assign dbg_state_o = state_q;
    assign dbg_pend_o  = pend_q;
    assign dbg_timer_o = 16'(timer_q);
endmodule

// File: tb/tb_sdr_req_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sdr_req_arbiter
// Self-checking bench for sdr_req_arbiter. One process drives everything in
// lock-step through tick():
//   1. The reference model is advanced using the inputs the DUT samples at
//      the coming posedge.
//   2. At the negedge, every observable output is compared with the model.
//   3. The emulated controller reacts to the DUT outputs.
// The model describes the arbiter at the transaction level:
//   - who owns the port;
//   - which master is due next;
//   - the refresh credits elapsed minus the refreshes acknowledged.
// Directed sections pin the model with literal expectations. A random
// section then exercises the rest.
// -----------------------------------------------------------------------------
module tb_sdr_req_arbiter;
    localparam int RI  = 8;
    localparam int URG = 4;

    logic        sys_CLK;
    logic        sys_RESET;
    logic [2:0]  dbg_state;
    logic [2:0]  dbg_pend;
    logic [15:0] dbg_timer;

    sdr_req_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    sdr_req_arbiter #(
        .ADDR_W(16), .DATA_W(16), .REF_INTERVAL(RI), .REF_URGENT(URG)
    ) dut (
        .sys_CLK     (sys_CLK),
        .sys_RESET   (sys_RESET),
        .bus         (bus),
        .dbg_state_o (dbg_state),
        .dbg_pend_o  (dbg_pend),
        .dbg_timer_o (dbg_timer)
    );

    // ---------------- clock ----------------
    initial sys_CLK = 1'b0;
    always #5 sys_CLK = ~sys_CLK;

    // ---------------- bookkeeping ----------------
    int n_chk  = 0;
    int n_fail = 0;
    logic [15:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef enum {P_INIT, P_FREE, P_GRANT, P_ACCESS, P_REFRESH} ph_t;
    ph_t         ph;
    bit          mdl_ok = 1'b0;
    int          m_ticks;    // active cycles modulo RI
    int          m_backlog;  // credits earned minus refreshes acked, capped at 7
    bit          m_ovf;
    int          m_next;     // master that wins a tie
    int          m_owner;
    logic [1:0]  e_gnt, e_done, e_rdv;
    logic [15:0] e_rdd, e_a, e_d;
    logic        e_rwn, e_adsn, e_ref;

    task automatic model_step();
        ph_t old_ph;
        int  old_backlog;
        bit  credit, acked;
        int  g;
        if (!sys_RESET) begin
            ph = P_INIT; m_ticks = 0; m_backlog = 0; m_ovf = 0; m_next = 0; m_owner = 0;
            e_gnt = 0; e_done = 0; e_rdv = 0; e_rdd = 0; e_a = 0; e_d = 0;
            e_rwn = 1; e_adsn = 1; e_ref = 0;
            mdl_ok = 1'b1;
            return;
        end
        old_ph      = ph;
        old_backlog = m_backlog;
        e_gnt = 0; e_done = 0; e_rdv = 0; e_adsn = 1;
        credit = (old_ph != P_INIT) && (m_ticks == RI - 1);
        acked  = (old_ph == P_REFRESH) && e_ref && bus.sys_REF_ACK;
        case (old_ph)
            P_INIT: if (bus.sys_INIT_DONE) ph = P_FREE;
            P_FREE: begin
                if (old_backlog >= URG || (bus.m_req == 2'b00 && old_backlog != 0)) begin
                    ph = P_REFRESH; e_ref = 1;
                end else if (bus.m_req != 2'b00) begin
                    if (bus.m_req == 2'b11) g = m_next;
                    else                    g = bus.m_req[1] ? 1 : 0;
                    m_next  = 1 - g;
                    m_owner = g;
                    e_gnt   = (g == 1) ? 2'b10 : 2'b01;
                    e_a     = (g == 1) ? bus.m1_addr  : bus.m0_addr;
                    e_d     = (g == 1) ? bus.m1_wdata : bus.m0_wdata;
                    e_rwn   = ~bus.m_wr[g];
                    ph      = P_GRANT;
                end
            end
            P_GRANT: begin e_adsn = 0; ph = P_ACCESS; end
            P_ACCESS: begin
                if (bus.sys_D_VALID) begin
                    e_rdv = (m_owner == 1) ? 2'b10 : 2'b01;
                    e_rdd = bus.sys_D_in;
                end
                if (bus.sys_CYC_END) begin
                    e_done = (m_owner == 1) ? 2'b10 : 2'b01;
                    ph     = P_FREE;
                end
            end
            P_REFRESH: begin
                if (acked) e_ref = 0;
                else if (!e_ref && bus.sys_CYC_END) ph = P_FREE;
            end
            default: ph = P_INIT;
        endcase
        if (old_ph != P_INIT) m_ticks = (m_ticks + 1) % RI;
        if (credit && !acked) begin
            if (m_backlog == 7) m_ovf = 1;
            else                m_backlog++;
        end else if (acked && !credit) begin
            m_backlog--;
        end
    endtask

    task automatic compare();
        chk("m_gnt",    32'(bus.m_gnt),       32'(e_gnt));
        chk("m_done",   32'(bus.m_done),      32'(e_done));
        chk("rd_valid", 32'(bus.rd_valid),    32'(e_rdv));
        chk("rd_data",  32'(bus.rd_data),     32'(e_rdd));
        chk("sys_ADSn", 32'(bus.sys_ADSn),    32'(e_adsn));
        chk("sys_R_Wn", 32'(bus.sys_R_Wn),    32'(e_rwn));
        chk("sys_A",    32'(bus.sys_A),       32'(e_a));
        chk("sys_D",    32'(bus.sys_D),       32'(e_d));
        chk("REF_REQ",  32'(bus.sys_REF_REQ), 32'(e_ref));
        chk("ref_ovf",  32'(bus.ref_ovf),     32'(m_ovf));
        chk("pend",     32'(dbg_pend),        32'(m_backlog));
        chk("timer",    32'(dbg_timer),       32'(m_ticks));
    endtask

    // ---------------- controller emulation ----------------
    int          c_mode = 0;   // 0 idle, 1 access, 2 refresh
    int          c_cnt  = 0;
    bit          c_rd   = 0;
    bit          hold_ack = 0;
    bit          fix_en   = 0;
    logic [15:0] fix_val  = 16'h0;

    task automatic ctl_step();
        bus.sys_D_VALID = 1'b0;
        bus.sys_CYC_END = 1'b0;
        bus.sys_REF_ACK = 1'b0;
        bus.sys_D_in    = 16'($urandom);
        if (!sys_RESET) begin
            c_mode = 0;
            return;
        end
        case (c_mode)
            0: begin
                if (bus.sys_ADSn == 1'b0) begin
                    c_mode = 1; c_cnt = $urandom_range(2, 4); c_rd = bus.sys_R_Wn;
                end else if (bus.sys_REF_REQ && !hold_ack && $urandom_range(0, 1) == 1) begin
                    bus.sys_REF_ACK = 1'b1; c_mode = 2; c_cnt = $urandom_range(1, 3);
                end
            end
            1: begin
                c_cnt--;
                if (c_cnt == 1 && c_rd) begin
                    bus.sys_D_VALID = 1'b1;
                    if (fix_en) bus.sys_D_in = fix_val;
                end
                if (c_cnt == 0) begin bus.sys_CYC_END = 1'b1; c_mode = 0; end
            end
            default: begin
                c_cnt--;
                if (c_cnt == 0) begin bus.sys_CYC_END = 1'b1; c_mode = 0; end
            end
        endcase
    endtask

    // ---------------- driver helpers ----------------
    task automatic tick();
        model_step();
        @(negedge sys_CLK);
        if (mdl_ok) compare();
        ctl_step();
    endtask

    task automatic new_payload(input int i);
        if (i == 0) begin
            bus.m0_addr = 16'($urandom); bus.m0_wdata = 16'($urandom);
        end else begin
            bus.m1_addr = 16'($urandom); bus.m1_wdata = 16'($urandom);
        end
        bus.m_wr[i] = 1'($urandom_range(0, 1));
    endtask

    task automatic random_masters();
        for (int i = 0; i < 2; i++) begin
            if (bus.m_req[i]) begin
                if (bus.m_gnt[i]) begin
                    if ($urandom_range(0, 2) == 0) new_payload(i);
                    else bus.m_req[i] = 1'b0;
                end else if ($urandom_range(0, 15) == 0) begin
                    bus.m_req[i] = 1'b0;
                end
            end else if ($urandom_range(0, 3) == 0) begin
                new_payload(i);
                bus.m_req[i] = 1'b1;
            end
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int k;
        int p_prev;
        sys_RESET = 1'b0;
        bus.sys_INIT_DONE = 1'b0;
        bus.sys_D_in = 16'h0; bus.sys_D_VALID = 1'b0;
        bus.sys_CYC_END = 1'b0; bus.sys_REF_ACK = 1'b0;
        bus.m_wr = 2'b01;
        bus.m0_addr = 16'h1A85; bus.m0_wdata = 16'hBEEF;
        bus.m1_addr = 16'h0321; bus.m1_wdata = 16'h0000;
        bus.m_req = 2'b11;

        repeat (3) tick();
        sys_RESET = 1'b1;

        // Initialisation gate: requests pending, but nothing is granted.
        repeat (20) tick();
        chk("init_no_gnt",  32'(bus.m_gnt),    32'h0);
        chk("init_adsn",    32'(bus.sys_ADSn), 32'h1);
        chk("init_timer",   32'(dbg_timer),    32'h0);
        bus.sys_INIT_DONE = 1'b1;
        tick();
        tick();
        chk("first_gnt",    32'(bus.m_gnt),    32'h1);
        chk("wr_addr",      32'(bus.sys_A),    32'h1A85);
        chk("wr_data",      32'(bus.sys_D),    32'hBEEF);
        chk("wr_rwn",       32'(bus.sys_R_Wn), 32'h0);
        bus.m_req[0] = 1'b0;
        tick();
        chk("adsn_low",     32'(bus.sys_ADSn), 32'h0);
        tick();
        chk("adsn_high",    32'(bus.sys_ADSn), 32'h1);
        k = 0;
        while (bus.m_done == 2'b00 && k < 20) begin tick(); k++; end
        chk("wr_done",      32'(bus.m_done),   32'h1);

        // m1 read returning fixed data.
        fix_en = 1; fix_val = 16'h5A5A;
        k = 0;
        while (bus.m_gnt == 2'b00 && k < 100) begin tick(); k++; end
        chk("rd_gnt",       32'(bus.m_gnt),    32'h2);
        bus.m_req[1] = 1'b0;
        k = 0;
        while (bus.rd_valid == 2'b00 && k < 100) begin tick(); k++; end
        chk("rd_valid",     32'(bus.rd_valid), 32'h2);
        chk("rd_data",      32'(bus.rd_data),  32'h5A5A);
        k = 0;
        while (bus.m_done == 2'b00 && k < 100) begin tick(); k++; end
        chk("rd_done",      32'(bus.m_done),   32'h2);
        fix_en = 0;

        // Both masters continuously requesting: strict alternation.
        for (int i = 0; i < 6; i++) exp_q.push_back(16'(i % 2));
        new_payload(0); new_payload(1);
        bus.m_req = 2'b11;
        for (int i = 0; i < 6; i++) begin
            k = 0;
            do begin tick(); k++; end while (bus.m_gnt == 2'b00 && k < 200);
            chk("rr_order", 32'(bus.m_gnt[1]), 32'(exp_q.pop_front()));
            new_payload(0); new_payload(1);
        end
        bus.m_req = 2'b00;

        // Drain the backlog while idle.
        k = 0;
        while (!(ph == P_FREE && m_backlog == 0) && k < 400) begin tick(); k++; end
        chk("drain", 32'(ph == P_FREE && m_backlog == 0), 32'h1);

        // Urgent refresh preempts continuous m0 traffic. The ack is withheld.
        hold_ack = 1;
        new_payload(0);
        bus.m_req = 2'b01;
        k = 0;
        while (!bus.sys_REF_REQ && k < 300) begin
            tick(); k++;
            if (bus.m_gnt[0]) new_payload(0);
        end
        chk("urgent_ref_req", 32'(bus.sys_REF_REQ), 32'h1);
        chk("urgent_pend",    32'(dbg_pend >= 3'(URG)), 32'h1);
        repeat (6) tick();
        chk("ref_req_held",   32'(bus.sys_REF_REQ), 32'h1);
        hold_ack = 0;
        k = 0;
        p_prev = dbg_pend;
        while (bus.sys_REF_REQ && k < 50) begin p_prev = dbg_pend; tick(); k++; end
        chk("ack_drop",       32'(bus.sys_REF_REQ), 32'h0);
        chk("pend_after_ack", 32'(dbg_pend == 3'(p_prev - 1) || dbg_pend == 3'(p_prev)), 32'h1);
        bus.m_req = 2'b00;

        // Saturation: the refresh is never acknowledged.
        hold_ack = 1;
        k = 0;
        while (!bus.sys_REF_REQ && k < 100) begin tick(); k++; end
        repeat (8 * RI + 8) tick();
        chk("sat_pend", 32'(dbg_pend),    32'h7);
        chk("sat_ovf",  32'(bus.ref_ovf), 32'h1);
        hold_ack = 0;

        // Random traffic. INIT_DONE may fall now and must be ignored.
        for (int i = 0; i < 1500; i++) begin
            tick();
            random_masters();
            bus.sys_INIT_DONE = ($urandom_range(0, 7) != 0);
        end
        chk("ovf_sticky", 32'(bus.ref_ovf), 32'h1);

        // Reset in the middle of traffic.
        sys_RESET = 1'b0;
        bus.m_req = 2'b00;
        bus.sys_INIT_DONE = 1'b0;
        tick();
        tick();
        chk("rst_ovf",     32'(bus.ref_ovf),     32'h0);
        chk("rst_adsn",    32'(bus.sys_ADSn),    32'h1);
        chk("rst_ref_req", 32'(bus.sys_REF_REQ), 32'h0);
        chk("rst_rd_data", 32'(bus.rd_data),     32'h0);
        chk("rst_pend",    32'(dbg_pend),        32'h0);
        sys_RESET = 1'b1;
        repeat (5) tick();
        bus.sys_INIT_DONE = 1'b1;
        for (int i = 0; i < 600; i++) begin
            tick();
            random_masters();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
